id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus EX-stage operand forwarding. It captures decode-stage operands and
//  control, then presents forwarded Src_AE/Src_BE, ALU_Instruction_E and shamt_E to the main ALU.
//  It also provides Write_Data_E and Write_Reg_E for the EX/MEM register.
//  Honours hazard-unit stall (hold) and flush (bubble) requests.
// PARAMETERS
//  DATA_W      32  datapath width
//  REG_ADDR_W  5   register-file address width
//  ALU_CTRL_W  4   ALU control code width
// PORTS
//  clk              in   1           rising-edge clock
//  rst              in   1           synchronous, active-high reset
//  Stall_E          in   1           hold the current E-stage contents
//  Flush_E          in   1           load a bubble
//  RD1_D, RD2_D     in   DATA_W      register-file read data (rs, rt)
//  Rs_D, Rt_D, Rd_D in   REG_ADDR_W  register specifiers
//  Sign_Imm_D       in   DATA_W      sign-extended immediate
//  shamt_D          in   5           shift amount
//  ALU_Control_D    in   ALU_CTRL_W  ALU operation code
//  ALU_Src_D        in   1           1: Src_BE = immediate
//  Reg_Dst_D        in   1           1: destination = Rd, 0: Rt
//  Reg_Write_D, Mem_Write_D, Mem_to_Reg_D  in  1 each  control bits
//  ALU_Result_M     in   DATA_W      M-stage result (forward source)
//  Write_Reg_M      in   REG_ADDR_W  M-stage destination
//  Reg_Write_M      in   1
//  Result_W         in   DATA_W      W-stage result (forward source)
//  Write_Reg_W      in   REG_ADDR_W  W-stage destination
//  Reg_Write_W      in   1
//  Src_AE, Src_BE   out  DATA_W      ALU operands
//  Write_Data_E     out  DATA_W      forwarded rt value, for stores
//  Write_Reg_E      out  REG_ADDR_W  selected destination register
//  ALU_Instruction_E out ALU_CTRL_W  registered ALU_Control_D
//  shamt_E          out  5
//  Rs_E, Rt_E       out  REG_ADDR_W  to hazard unit
//  Reg_Write_E, Mem_Write_E, Mem_to_Reg_E, Valid_E  out  1 each
// BEHAVIOUR
//  - Register update at posedge clk. Priority: rst > Flush_E > Stall_E > load from D inputs.
//  - rst or Flush_E: every registered field := 0, Valid_E := 0. A bubble therefore has
//    ALU_Instruction_E = 4'b0000 (AND) and no write or memory side effects.
//  - Stall_E: all registered fields hold. Forward muxes keep re-evaluating M/W every cycle.
//  - Load: fields := D inputs, Valid_E := 1. Latency is one cycle from D inputs to E outputs.
//  - Flush_E together with Stall_E: flush wins.
//  - Forward A, combinational on registered Rs_E:
//      if Reg_Write_M && Write_Reg_M == Rs_E && Rs_E != 0  -> ALU_Result_M
//      else if Reg_Write_W && Write_Reg_W == Rs_E && Rs_E != 0 -> Result_W
//      else RD1_E
//  - Forward B: identical rule on Rt_E / RD2_E, giving fwdB. M has priority over W.
//  - Src_AE = fwdA.
//  - Src_BE = ALU_Src_E ? Sign_Imm_E : fwdB.
//  - Write_Data_E = fwdB, independent of ALU_Src_E.
//  - Write_Reg_E = Reg_Dst_E ? Rd_E : Rt_E.
//  - Register $0 is never forwarded: RD1_E/RD2_E pass through unchanged, even when M or W
//    targets $0 with its write enable set.
//  - Outputs after reset, with no forwarding active: all outputs 0.
//  - No arithmetic in this block; widths pass through unchanged.
// TESTING
//  1. rst=1 for 2 cycles with arbitrary D inputs -> all outputs 0, Valid_E=0.
//  2. Load RD1_D=5, RD2_D=7, ALU_Control_D=4'b0010, ALU_Src_D=0, no hazards
//     -> next cycle Src_AE=5, Src_BE=7, ALU_Instruction_E=2, Valid_E=1.
//  3. Rs_E=3, Write_Reg_M=3, Reg_Write_M=1, ALU_Result_M=0x11, and Write_Reg_W=3,
//     Reg_Write_W=1, Result_W=0x22 -> Src_AE=0x11 (M priority).
//     Then drop Reg_Write_M -> Src_AE=0x22.
//  4. Rt_E=0, Write_Reg_M=0, Reg_Write_M=1, ALU_Result_M=0xFF, RD2_E=0 -> Src_BE=0 (no $0 forward).
//  5. ALU_Src_E=1, Sign_Imm_E=0xFFFFFFFC, Rt_E forwarded from M with 0x99
//     -> Src_BE=0xFFFFFFFC, Write_Data_E=0x99.
//  6. Stall_E=1 while D inputs change -> E outputs unchanged.
//     Stall_E=1 and Flush_E=1 together -> next cycle bubble: Reg_Write_E=0, Mem_Write_E=0,
//     Valid_E=0.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus: decode-side operands and control, hazard-unit
// stall/flush, M/W forwarding sources, and the E-stage outputs.
interface id_ex_operand_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4
);
  // Hazard unit requests
  logic                  Stall_E;
  logic                  Flush_E;

  // Decode-stage operands and control
  logic [DATA_W-1:0]     RD1_D;
  logic [DATA_W-1:0]     RD2_D;
  logic [REG_ADDR_W-1:0] Rs_D;
  logic [REG_ADDR_W-1:0] Rt_D;
  logic [REG_ADDR_W-1:0] Rd_D;
  logic [DATA_W-1:0]     Sign_Imm_D;
  logic [4:0]            shamt_D;
  logic [ALU_CTRL_W-1:0] ALU_Control_D;
  logic                  ALU_Src_D;
  logic                  Reg_Dst_D;
  logic                  Reg_Write_D;
  logic                  Mem_Write_D;
  logic                  Mem_to_Reg_D;

  // Forwarding sources from later stages
  logic [DATA_W-1:0]     ALU_Result_M;
  logic [REG_ADDR_W-1:0] Write_Reg_M;
  logic                  Reg_Write_M;
  logic [DATA_W-1:0]     Result_W;
  logic [REG_ADDR_W-1:0] Write_Reg_W;
  logic                  Reg_Write_W;

  // Execute-stage outputs
  logic [DATA_W-1:0]     Src_AE;
  logic [DATA_W-1:0]     Src_BE;
  logic [DATA_W-1:0]     Write_Data_E;
  logic [REG_ADDR_W-1:0] Write_Reg_E;
  logic [ALU_CTRL_W-1:0] ALU_Instruction_E;
  logic [4:0]            shamt_E;
  logic [REG_ADDR_W-1:0] Rs_E;
  logic [REG_ADDR_W-1:0] Rt_E;
  logic                  Reg_Write_E;
  logic                  Mem_Write_E;
  logic                  Mem_to_Reg_E;
  logic                  Valid_E;

  // Pipeline/environment side: drives D, hazard and forwarding inputs.
  modport master (
    output Stall_E, Flush_E,
    output RD1_D, RD2_D, Rs_D, Rt_D, Rd_D, Sign_Imm_D, shamt_D, ALU_Control_D,
    output ALU_Src_D, Reg_Dst_D, Reg_Write_D, Mem_Write_D, Mem_to_Reg_D,
    output ALU_Result_M, Write_Reg_M, Reg_Write_M,
    output Result_W, Write_Reg_W, Reg_Write_W,
    input  Src_AE, Src_BE, Write_Data_E, Write_Reg_E, ALU_Instruction_E, shamt_E,
    input  Rs_E, Rt_E, Reg_Write_E, Mem_Write_E, Mem_to_Reg_E, Valid_E
  );

  // The operand stage itself.
  modport slave (
    input  Stall_E, Flush_E,
    input  RD1_D, RD2_D, Rs_D, Rt_D, Rd_D, Sign_Imm_D, shamt_D, ALU_Control_D,
    input  ALU_Src_D, Reg_Dst_D, Reg_Write_D, Mem_Write_D, Mem_to_Reg_D,
    input  ALU_Result_M, Write_Reg_M, Reg_Write_M,
    input  Result_W, Write_Reg_W, Reg_Write_W,
    output Src_AE, Src_BE, Write_Data_E, Write_Reg_E, ALU_Instruction_E, shamt_E,
    output Rs_E, Rt_E, Reg_Write_E, Mem_Write_E, Mem_to_Reg_E, Valid_E
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding from M and W.
// Presents forwarded ALU operands, the store data and the destination register.
module id_ex_operand_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  id_ex_operand_stage_if.slave bus
);

  // Registered E-stage fields
  logic [DATA_W-1:0]     rd1_e;
  logic [DATA_W-1:0]     rd2_e;
  logic [REG_ADDR_W-1:0] rs_e;
  logic [REG_ADDR_W-1:0] rt_e;
  logic [REG_ADDR_W-1:0] rd_e;
  logic [DATA_W-1:0]     sign_imm_e;
  logic [4:0]            shamt_e;
  logic [ALU_CTRL_W-1:0] alu_ctrl_e;
  logic                  alu_src_e;
  logic                  reg_dst_e;
  logic                  reg_write_e;
  logic                  mem_write_e;
  logic                  mem_to_reg_e;
  logic                  valid_e;

  // Forwarded operands
  logic [DATA_W-1:0]     fwd_a;
  logic [DATA_W-1:0]     fwd_b;

  // Forward select: M beats W; register $0 is hard-wired and never forwarded.
  function automatic logic [DATA_W-1:0] forward_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [DATA_W-1:0]     reg_val,
    input logic                  wr_m,
    input logic [REG_ADDR_W-1:0] dst_m,
    input logic [DATA_W-1:0]     val_m,
    input logic                  wr_w,
    input logic [REG_ADDR_W-1:0] dst_w,
    input logic [DATA_W-1:0]     val_w
  );
    logic [DATA_W-1:0] sel;
    sel = reg_val;
    if (src != '0) begin
      if (wr_m && (dst_m == src)) begin
        sel = val_m;
      end else if (wr_w && (dst_w == src)) begin
        sel = val_w;
      end
    end
    return sel;
  endfunction

  // ID/EX register: reset and flush load a bubble, stall holds, otherwise load D.
  always_ff @(posedge clk) begin
    if (rst || bus.Flush_E) begin
      rd1_e        <= '0;
      rd2_e        <= '0;
      rs_e         <= '0;
      rt_e         <= '0;
      rd_e         <= '0;
      sign_imm_e   <= '0;
      shamt_e      <= '0;
      alu_ctrl_e   <= '0;
      alu_src_e    <= 1'b0;
      reg_dst_e    <= 1'b0;
      reg_write_e  <= 1'b0;
      mem_write_e  <= 1'b0;
      mem_to_reg_e <= 1'b0;
      valid_e      <= 1'b0;
    end else if (!bus.Stall_E) begin
      rd1_e        <= bus.RD1_D;
      rd2_e        <= bus.RD2_D;
      rs_e         <= bus.Rs_D;
      rt_e         <= bus.Rt_D;
      rd_e         <= bus.Rd_D;
      sign_imm_e   <= bus.Sign_Imm_D;
      shamt_e      <= bus.shamt_D;
      alu_ctrl_e   <= bus.ALU_Control_D;
      alu_src_e    <= bus.ALU_Src_D;
      reg_dst_e    <= bus.Reg_Dst_D;
      reg_write_e  <= bus.Reg_Write_D;
      mem_write_e  <= bus.Mem_Write_D;
      mem_to_reg_e <= bus.Mem_to_Reg_D;
      valid_e      <= 1'b1;
    end
  end

  // Forwarding muxes re-evaluate M/W every cycle, including while stalled.
  always_comb begin
    fwd_a = forward_sel(rs_e, rd1_e,
                        bus.Reg_Write_M, bus.Write_Reg_M, bus.ALU_Result_M,
                        bus.Reg_Write_W, bus.Write_Reg_W, bus.Result_W);
    fwd_b = forward_sel(rt_e, rd2_e,
                        bus.Reg_Write_M, bus.Write_Reg_M, bus.ALU_Result_M,
                        bus.Reg_Write_W, bus.Write_Reg_W, bus.Result_W);
  end

  // Operand and destination selection for the ALU and EX/MEM register.
  always_comb begin
    bus.Src_AE       = fwd_a;
    bus.Src_BE       = alu_src_e ? sign_imm_e : fwd_b;
    bus.Write_Data_E = fwd_b;
    bus.Write_Reg_E  = reg_dst_e ? rd_e : rt_e;
  end

  assign bus.ALU_Instruction_E = alu_ctrl_e;
  assign bus.shamt_E           = shamt_e;
  assign bus.Rs_E              = rs_e;
  assign bus.Rt_E              = rt_e;
  assign bus.Reg_Write_E       = reg_write_e;
  assign bus.Mem_Write_E       = mem_write_e;
  assign bus.Mem_to_Reg_E      = mem_to_reg_e;
  assign bus.Valid_E           = valid_e;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus a
// randomized run against an instruction-level model of the E stage.
module tb_id_ex_operand_stage;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CW    = 4;
  localparam int OUT_W = 3*DW + 3*AW + CW + 5 + 4;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [4:0]    shamt;
    logic [CW-1:0] alu;
    logic          alu_src;
    logic          reg_dst;
    logic          rw;
    logic          mw;
    logic          m2r;
  } instr_t;

  logic   clk = 1'b0;
  logic   rst;
  instr_t m;   // instruction the model believes sits in E
  int     n_checks = 0;
  int     n_fail   = 0;

  id_ex_operand_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW), .ALU_CTRL_W(CW)) bus ();

  id_ex_operand_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .ALU_CTRL_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Value an ALU operand register should see given the in-flight writers.
  function automatic logic [DW-1:0] operand(input logic [AW-1:0] r, input logic [DW-1:0] file_val);
    if (r == 0) return file_val;
    if (bus.Reg_Write_M && bus.Write_Reg_M == r) return bus.ALU_Result_M;
    if (bus.Reg_Write_W && bus.Write_Reg_W == r) return bus.Result_W;
    return file_val;
  endfunction

  function automatic logic [OUT_W-1:0] expected_outs();
    logic [DW-1:0] a, b;
    a = operand(m.rs, m.rd1);
    b = operand(m.rt, m.rd2);
    return {a, (m.alu_src ? m.imm : b), b, (m.reg_dst ? m.rd : m.rt), m.alu, m.shamt,
            m.rs, m.rt, m.rw, m.mw, m.m2r, m.valid};
  endfunction

  function automatic logic [OUT_W-1:0] dut_outs();
    return {bus.Src_AE, bus.Src_BE, bus.Write_Data_E, bus.Write_Reg_E, bus.ALU_Instruction_E,
            bus.shamt_E, bus.Rs_E, bus.Rt_E, bus.Reg_Write_E, bus.Mem_Write_E,
            bus.Mem_to_Reg_E, bus.Valid_E};
  endfunction

  // One clock: the model takes the instruction the D inputs describe, then settle.
  task automatic step();
    instr_t nxt;
    if (rst || bus.Flush_E) nxt = '0;
    else if (bus.Stall_E)   nxt = m;
    else nxt = '{valid: 1'b1, rd1: bus.RD1_D, rd2: bus.RD2_D, imm: bus.Sign_Imm_D,
                 rs: bus.Rs_D, rt: bus.Rt_D, rd: bus.Rd_D, shamt: bus.shamt_D,
                 alu: bus.ALU_Control_D, alu_src: bus.ALU_Src_D, reg_dst: bus.Reg_Dst_D,
                 rw: bus.Reg_Write_D, mw: bus.Mem_Write_D, m2r: bus.Mem_to_Reg_D};
    @(posedge clk);
    m = nxt;
    #1;
  endtask

  task automatic random_d(input int max_reg);
    bus.RD1_D         = $urandom;
    bus.RD2_D         = $urandom;
    bus.Rs_D          = AW'($urandom_range(0, max_reg));
    bus.Rt_D          = AW'($urandom_range(0, max_reg));
    bus.Rd_D          = AW'($urandom_range(0, max_reg));
    bus.Sign_Imm_D    = $urandom;
    bus.shamt_D       = 5'($urandom);
    bus.ALU_Control_D = CW'($urandom);
    bus.ALU_Src_D     = 1'($urandom);
    bus.Reg_Dst_D     = 1'($urandom);
    bus.Reg_Write_D   = 1'($urandom);
    bus.Mem_Write_D   = 1'($urandom);
    bus.Mem_to_Reg_D  = 1'($urandom);
  endtask

  task automatic random_mw(input int max_reg);
    bus.ALU_Result_M = $urandom;
    bus.Write_Reg_M  = AW'($urandom_range(0, max_reg));
    bus.Reg_Write_M  = 1'($urandom);
    bus.Result_W     = $urandom;
    bus.Write_Reg_W  = AW'($urandom_range(0, max_reg));
    bus.Reg_Write_W  = 1'($urandom);
  endtask

  task automatic no_forwarding();
    bus.Reg_Write_M = 1'b0;
    bus.Reg_Write_W = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Stall_E = 1'b0;
    bus.Flush_E = 1'b0;
    random_d(31);
    random_mw(31);
    step();
    random_d(31);
    step();
    n_checks++;
    if (dut_outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", dut_outs());
    end
    n_checks++;
    if (bus.Valid_E !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b expected 0", bus.Valid_E);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    no_forwarding();
    random_d(31);
    bus.RD1_D = 32'd5;  bus.RD2_D = 32'd7;
    bus.Rs_D = 5'd1;    bus.Rt_D = 5'd2;
    bus.ALU_Control_D = 4'b0010;
    bus.ALU_Src_D = 1'b0;
    step();
    n_checks++;
    if ({bus.Src_AE, bus.Src_BE, bus.ALU_Instruction_E, bus.Valid_E} !== {32'd5, 32'd7, 4'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL load_basic: got A=%h B=%h alu=%h v=%b expected A=5 B=7 alu=2 v=1",
               bus.Src_AE, bus.Src_BE, bus.ALU_Instruction_E, bus.Valid_E);
    end
    n_checks++;
    if (dut_outs() !== expected_outs()) begin
      n_fail++;
      $display("FAIL load_all: got %h expected %h", dut_outs(), expected_outs());
    end
  endtask

  task automatic test_forward_priority();
    random_d(31);
    bus.Rs_D = 5'd3; bus.RD1_D = 32'h33;
    no_forwarding();
    step();
    bus.Write_Reg_M = 5'd3; bus.Reg_Write_M = 1'b1; bus.ALU_Result_M = 32'h11;
    bus.Write_Reg_W = 5'd3; bus.Reg_Write_W = 1'b1; bus.Result_W     = 32'h22;
    #1;
    n_checks++;
    if (bus.Src_AE !== 32'h11) begin
      n_fail++;
      $display("FAIL fwd_m_priority: got %h expected 00000011", bus.Src_AE);
    end
    bus.Reg_Write_M = 1'b0;
    #1;
    n_checks++;
    if (bus.Src_AE !== 32'h22) begin
      n_fail++;
      $display("FAIL fwd_w_only: got %h expected 00000022", bus.Src_AE);
    end
    bus.Reg_Write_W = 1'b0;
    #1;
    n_checks++;
    if (bus.Src_AE !== 32'h33) begin
      n_fail++;
      $display("FAIL fwd_none: got %h expected 00000033", bus.Src_AE);
    end
  endtask

  task automatic test_zero_reg();
    random_d(31);
    bus.Rt_D = 5'd0; bus.RD2_D = 32'h0; bus.ALU_Src_D = 1'b0;
    bus.Rs_D = 5'd0; bus.RD1_D = 32'h0;
    no_forwarding();
    step();
    bus.Write_Reg_M = 5'd0; bus.Reg_Write_M = 1'b1; bus.ALU_Result_M = 32'hFF;
    bus.Write_Reg_W = 5'd0; bus.Reg_Write_W = 1'b1; bus.Result_W     = 32'hEE;
    #1;
    n_checks++;
    if ({bus.Src_AE, bus.Src_BE, bus.Write_Data_E} !== '0) begin
      n_fail++;
      $display("FAIL zero_reg_no_fwd: got A=%h B=%h WD=%h expected all 0",
               bus.Src_AE, bus.Src_BE, bus.Write_Data_E);
    end
  endtask

  task automatic test_alu_src();
    random_d(31);
    bus.ALU_Src_D = 1'b1; bus.Sign_Imm_D = 32'hFFFF_FFFC;
    bus.Rt_D = 5'd4; bus.RD2_D = 32'h44;
    bus.Reg_Dst_D = 1'b1; bus.Rd_D = 5'd9;
    no_forwarding();
    step();
    bus.Write_Reg_M = 5'd4; bus.Reg_Write_M = 1'b1; bus.ALU_Result_M = 32'h99;
    #1;
    n_checks++;
    if ({bus.Src_BE, bus.Write_Data_E} !== {32'hFFFF_FFFC, 32'h99}) begin
      n_fail++;
      $display("FAIL alu_src_imm: got B=%h WD=%h expected B=fffffffc WD=00000099",
               bus.Src_BE, bus.Write_Data_E);
    end
    n_checks++;
    if (bus.Write_Reg_E !== 5'd9) begin
      n_fail++;
      $display("FAIL reg_dst_rd: got %0d expected 9", bus.Write_Reg_E);
    end
  endtask

  task automatic test_stall_flush();
    logic [OUT_W-1:0] held;
    random_d(31);
    bus.Reg_Write_D = 1'b1; bus.Mem_Write_D = 1'b1;
    no_forwarding();
    step();
    held = dut_outs();
    bus.Stall_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      random_d(31);
      step();
      n_checks++;
      if (dut_outs() !== held) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", i, dut_outs(), held);
      end
    end
    bus.Flush_E = 1'b1;
    step();
    bus.Stall_E = 1'b0;
    bus.Flush_E = 1'b0;
    n_checks++;
    if ({bus.Reg_Write_E, bus.Mem_Write_E, bus.Valid_E, bus.ALU_Instruction_E} !== '0) begin
      n_fail++;
      $display("FAIL stall_flush_bubble: got rw=%b mw=%b v=%b alu=%h expected all 0",
               bus.Reg_Write_E, bus.Mem_Write_E, bus.Valid_E, bus.ALU_Instruction_E);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      random_d(3);
      random_mw(3);
      bus.Stall_E = ($urandom_range(0, 3) == 0);
      bus.Flush_E = ($urandom_range(0, 9) == 0);
      rst         = ($urandom_range(0, 29) == 0);
      step();
      n_checks++;
      if (dut_outs() !== expected_outs()) begin
        n_fail++;
        $display("FAIL random_edge[%0d]: got %h expected %h", i, dut_outs(), expected_outs());
      end
      random_mw(3);
      #1;
      n_checks++;
      if (dut_outs() !== expected_outs()) begin
        n_fail++;
        $display("FAIL random_refwd[%0d]: got %h expected %h", i, dut_outs(), expected_outs());
      end
    end
    rst = 1'b0;
    bus.Stall_E = 1'b0;
    bus.Flush_E = 1'b0;
  endtask

  initial begin
    m = '0;
    test_reset();
    test_load();
    test_forward_priority();
    test_zero_reg();
    test_alu_src();
    test_stall_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
